// File: rtl/uart_line_rx.sv
// Line assembler behind the uart receiver: collects bytes into a CR/LF-terminated line
// with backspace editing, holds it for the application and flags two fixed commands.
module uart_line_rx #(
  parameter int unsigned          MAX_LEN  = 8,
  parameter logic [8*MAX_LEN-1:0] CMD0     = "a",
  parameter int unsigned          CMD0_LEN = 1,
  parameter logic [8*MAX_LEN-1:0] CMD1     = "hello",
  parameter int unsigned          CMD1_LEN = 5,
  parameter int unsigned          LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_error,
  output logic             line_valid,
  output logic [LEN_W-1:0] line_len,
  output logic             match0,
  output logic             match1,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  input  logic             line_ack,
  output logic             line_err,
  output logic             rx_dropped
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {IDLE, COLLECT, MATCH, HOLD, DISCARD} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len, len_n;
  logic [7:0]       line_buf [MAX_LEN];
  logic             wr_en, capture, clear_line, err_n, drop_n;
  logic             is_term, is_bs, eq0, eq1;

  assign is_term = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign is_bs   = (rx_byte == 8'h08) || (rx_byte == 8'h7F);

  // Command strings are packed first-char-highest; shift the wanted char down to bit 0.
  always_comb begin
    eq0 = (len == LEN_W'(CMD0_LEN));
    for (int unsigned i = 0; i < CMD0_LEN; i++)
      if (line_buf[IDX_W'(i)] != 8'(CMD0 >> (8 * (CMD0_LEN - 1 - i)))) eq0 = 1'b0;
    eq1 = (len == LEN_W'(CMD1_LEN));
    for (int unsigned i = 0; i < CMD1_LEN; i++)
      if (line_buf[IDX_W'(i)] != 8'(CMD1 >> (8 * (CMD1_LEN - 1 - i)))) eq1 = 1'b0;
  end

  always_comb begin
    state_n    = state;
    len_n      = len;
    wr_en      = 1'b0;
    capture    = 1'b0;
    clear_line = 1'b0;
    err_n      = 1'b0;
    drop_n     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_error) begin
          state_n = DISCARD;
        end else if (rx_valid && !is_term && !is_bs) begin
          wr_en   = 1'b1;
          len_n   = LEN_W'(1);
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_error) begin
          state_n = DISCARD;
        end else if (rx_valid) begin
          if (is_term) begin
            state_n = MATCH;
          end else if (is_bs) begin
            len_n = len - 1'b1;
            if (len == LEN_W'(1)) state_n = IDLE;
          end else if (len == LEN_W'(MAX_LEN)) begin
            state_n = DISCARD;
          end else begin
            wr_en = 1'b1;
            len_n = len + 1'b1;
          end
        end
      end
      MATCH: begin
        capture = 1'b1;
        drop_n  = rx_valid;
        state_n = HOLD;
      end
      HOLD: begin
        drop_n = rx_valid;
        if (line_ack) begin
          clear_line = 1'b1;
          len_n      = '0;
          state_n    = IDLE;
        end
      end
      DISCARD: begin
        if (!rx_error && rx_valid && is_term) begin
          err_n   = 1'b1;
          len_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        len_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      line_valid <= 1'b0;
      line_len   <= '0;
      match0     <= 1'b0;
      match1     <= 1'b0;
      line_err   <= 1'b0;
      rx_dropped <= 1'b0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      line_err   <= err_n;
      rx_dropped <= drop_n;
      if (capture) begin
        line_valid <= 1'b1;
        line_len   <= len;
        match0     <= eq0;
        match1     <= eq1;
      end else if (clear_line) begin
        line_valid <= 1'b0;
        line_len   <= '0;
        match0     <= 1'b0;
        match1     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_buf[len[IDX_W-1:0]] <= rx_byte;
  end

  // line_len is zero outside HOLD, so this also blanks reads when no line is held.
  always_comb begin
    rd_data = '0;
    if (rd_addr < line_len) rd_data = line_buf[rd_addr[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_uart_line_rx.sv
// Scoreboard bench for uart_line_rx: a byte-level line model queues expected lines,
// which each scenario pops and compares once the DUT presents a held line.
module tb_uart_line_rx;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             rst, rx_valid, rx_error, line_ack;
  logic [7:0]       rx_byte;
  logic [LEN_W-1:0] rd_addr;
  logic             line_valid, match0, match1, line_err, rx_dropped;
  logic [LEN_W-1:0] line_len;
  logic [7:0]       rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                     len;
    logic [8*MAX_LEN-1:0]   bytes;
    logic                   m0;
    logic                   m1;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_buf [MAX_LEN];
  int         m_len  = 0;
  bit         m_disc = 1'b0;
  logic [39:0] hello_str = "hello";

  uart_line_rx #(.MAX_LEN(8), .CMD0("a"), .CMD0_LEN(1), .CMD1("hello"), .CMD1_LEN(5)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .line_valid(line_valid), .line_len(line_len), .match0(match0), .match1(match1),
    .rd_addr(rd_addr), .rd_data(rd_data), .line_ack(line_ack), .line_err(line_err),
    .rx_dropped(rx_dropped)
  );

  always #10 clk = ~clk;

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (b == 8'h0D || b == 8'h0A) begin
      if (m_disc) begin
        m_disc = 1'b0;
        m_len  = 0;
      end else if (m_len > 0) begin
        e.len   = m_len;
        e.bytes = '0;
        for (int i = 0; i < m_len; i++) e.bytes[8*i +: 8] = m_buf[i];
        e.m0 = (m_len == 1) && (m_buf[0] == 8'h61);
        e.m1 = (m_len == 5);
        if (e.m1)
          for (int i = 0; i < 5; i++)
            if (m_buf[i] != hello_str[8*(4-i) +: 8]) e.m1 = 1'b0;
        sb.push_back(e);
        m_len = 0;
      end
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (!m_disc && m_len > 0) m_len--;
    end else if (!m_disc) begin
      if (m_len == MAX_LEN) m_disc = 1'b1;
      else begin
        m_buf[m_len] = b;
        m_len++;
      end
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_text(input logic [8*MAX_LEN-1:0] s, input int n);
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      c = s[8*(n-1-i) +: 8];
      send_byte(c);
    end
  endtask

  task automatic send_err();
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    m_disc = 1'b1;
  endtask

  task automatic pulse_ack();
    line_ack = 1'b1;
    @(negedge clk);
    line_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({line_valid, line_len, match0, match1, line_err, rx_dropped, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b len=%0d m0=%b m1=%b err=%b drop=%b rd=%h required all 0",
               line_valid, line_len, match0, match1, line_err, rx_dropped, rd_data);
    end
    rst = 1'b0;
    line_ack = 1'b1;
    @(negedge clk);
    line_ack = 1'b0;
    checks++;
    if (line_valid !== 1'b0 || rx_dropped !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored: valid=%b drop=%b required 0 0", line_valid, rx_dropped);
    end
  endtask

  task automatic test_cmd0();
    exp_t e;
    logic [7:0] exp_b;
    send_byte(8'h61);
    send_byte(8'h0D);
    checks++;
    if (line_valid !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_early: line_valid=%b one cycle after CR, required 0", line_valid);
    end
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL cmd0_sb: DUT valid=%b, required a queued expected line", line_valid);
    end else begin
      e = sb.pop_front();
      if (line_valid !== 1'b1 || line_len !== LEN_W'(e.len) || match0 !== e.m0 || match1 !== e.m1) begin
        errors++;
        $display("FAIL cmd0_line: valid=%b len=%0d m0=%b m1=%b required 1 %0d %b %b",
                 line_valid, line_len, match0, match1, e.len, e.m0, e.m1);
      end
      for (int i = 0; i <= MAX_LEN; i++) begin
        rd_addr = LEN_W'(i);
        #1;
        exp_b = (i < e.len) ? e.bytes[8*i +: 8] : 8'h00;
        checks++;
        if (rd_data !== exp_b) begin
          errors++;
          $display("FAIL cmd0_rd[%0d]: rd_data=%h required %h", i, rd_data, exp_b);
        end
      end
      rd_addr = '0;
    end
    @(negedge clk);
    pulse_ack();
    checks++;
    if (line_valid !== 1'b0 || match0 !== 1'b0 || match1 !== 1'b0 || line_len !== '0) begin
      errors++;
      $display("FAIL cmd0_ack: valid=%b m0=%b m1=%b len=%0d required 0 0 0 0",
               line_valid, match0, match1, line_len);
    end
  endtask

  task automatic test_cmd1_crlf();
    exp_t e;
    send_text("hello", 5);
    send_byte(8'h0D);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL cmd1_sb: DUT valid=%b, required a queued expected line", line_valid);
    end else begin
      e = sb.pop_front();
      if (line_valid !== 1'b1 || line_len !== LEN_W'(e.len) || match0 !== e.m0 || match1 !== e.m1) begin
        errors++;
        $display("FAIL cmd1_line: valid=%b len=%0d m0=%b m1=%b required 1 %0d %b %b",
                 line_valid, line_len, match0, match1, e.len, e.m0, e.m1);
      end
    end
    pulse_ack();
    send_byte(8'h0A);
    repeat (3) @(negedge clk);
    checks++;
    if (line_valid !== 1'b0 || rx_dropped !== 1'b0 || line_err !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL cmd1_lf_no_line: valid=%b drop=%b err=%b queued=%0d required 0 0 0 0",
               line_valid, rx_dropped, line_err, sb.size());
    end
  endtask

  task automatic test_backspace();
    exp_t e;
    logic [7:0] exp_b;
    send_text("helx", 4);
    send_byte(8'h08);
    send_text("lo", 2);
    send_byte(8'h0D);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL bs_sb: DUT valid=%b, required a queued expected line", line_valid);
    end else begin
      e = sb.pop_front();
      if (line_valid !== 1'b1 || line_len !== LEN_W'(e.len) || match0 !== e.m0 || match1 !== e.m1) begin
        errors++;
        $display("FAIL bs_line: valid=%b len=%0d m0=%b m1=%b required 1 %0d %b %b",
                 line_valid, line_len, match0, match1, e.len, e.m0, e.m1);
      end
      for (int i = 0; i < e.len; i++) begin
        rd_addr = LEN_W'(i);
        #1;
        exp_b = e.bytes[8*i +: 8];
        checks++;
        if (rd_data !== exp_b) begin
          errors++;
          $display("FAIL bs_rd[%0d]: rd_data=%h required %h", i, rd_data, exp_b);
        end
      end
      rd_addr = '0;
    end
    @(negedge clk);
    pulse_ack();
    send_text("ab", 2);
    send_byte(8'h7F);
    send_byte(8'h08);
    send_byte(8'h0D);
    repeat (3) @(negedge clk);
    checks++;
    if (line_valid !== 1'b0 || line_err !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bs_empty_line: valid=%b err=%b queued=%0d required 0 0 0",
               line_valid, line_err, sb.size());
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    send_text("12345678", 8);
    send_byte(8'h39);
    send_byte(8'h0D);
    checks++;
    if (line_err !== 1'b1 || line_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err_pulse: err=%b valid=%b required 1 0", line_err, line_valid);
    end
    @(negedge clk);
    checks++;
    if (line_err !== 1'b0 || line_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL ovf_err_width: err=%b valid=%b queued=%0d required 0 0 0",
               line_err, line_valid, sb.size());
    end
    send_byte(8'h61);
    send_byte(8'h0D);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL ovf_recover_sb: DUT valid=%b, required a queued expected line", line_valid);
    end else begin
      e = sb.pop_front();
      if (line_valid !== 1'b1 || line_len !== LEN_W'(e.len) || match0 !== e.m0 || match1 !== e.m1) begin
        errors++;
        $display("FAIL ovf_recover: valid=%b len=%0d m0=%b m1=%b required 1 %0d %b %b",
                 line_valid, line_len, match0, match1, e.len, e.m0, e.m1);
      end
    end
    pulse_ack();
  endtask

  task automatic test_error_and_drop();
    exp_t e;
    send_text("he", 2);
    send_err();
    send_text("llo", 3);
    send_byte(8'h0D);
    checks++;
    if (line_err !== 1'b1 || line_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%b valid=%b required 1 0", line_err, line_valid);
    end
    // Error and terminator in the same cycle: the terminator must be swallowed.
    send_byte(8'h61);
    rx_byte = 8'h0D; rx_valid = 1'b1; rx_error = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_error = 1'b0;
    m_disc = 1'b1;
    checks++;
    if (line_err !== 1'b0 || line_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_wins: err=%b valid=%b required 0 0", line_err, line_valid);
    end
    send_byte(8'h0D);
    checks++;
    if (line_err !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL err_wins_close: err=%b queued=%0d required 1 0", line_err, sb.size());
    end
    send_text("hello", 5);
    send_byte(8'h0D);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL drop_sb: DUT valid=%b, required a queued expected line", line_valid);
    end else begin
      e = sb.pop_front();
      if (line_valid !== 1'b1 || line_len !== LEN_W'(e.len) || match1 !== e.m1) begin
        errors++;
        $display("FAIL drop_line: valid=%b len=%0d m1=%b required 1 %0d %b",
                 line_valid, line_len, match1, e.len, e.m1);
      end
    end
    rx_byte = 8'h41; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rd_addr = '0;
    #1;
    checks++;
    if (rx_dropped !== 1'b1 || line_valid !== 1'b1 || line_len !== LEN_W'(5) || match1 !== 1'b1 ||
        rd_data !== 8'h68) begin
      errors++;
      $display("FAIL hold_drop: drop=%b valid=%b len=%0d m1=%b rd0=%h required 1 1 5 1 68",
               rx_dropped, line_valid, line_len, match1, rd_data);
    end
    @(negedge clk);
    checks++;
    if (rx_dropped !== 1'b0) begin
      errors++;
      $display("FAIL hold_drop_width: drop=%b required 0", rx_dropped);
    end
    line_ack = 1'b1; rx_byte = 8'h41; rx_valid = 1'b1;
    @(negedge clk);
    line_ack = 1'b0; rx_valid = 1'b0;
    checks++;
    if (rx_dropped !== 1'b1 || line_valid !== 1'b0 || match1 !== 1'b0) begin
      errors++;
      $display("FAIL ack_and_byte: drop=%b valid=%b m1=%b required 1 0 0",
               rx_dropped, line_valid, match1);
    end
    send_byte(8'h61);
    send_byte(8'h0D);
    rx_byte = 8'h41; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL match_drop_sb: DUT valid=%b, required a queued expected line", line_valid);
    end else begin
      e = sb.pop_front();
      if (rx_dropped !== 1'b1 || line_valid !== 1'b1 || line_len !== LEN_W'(e.len) || match0 !== e.m0) begin
        errors++;
        $display("FAIL match_drop: drop=%b valid=%b len=%0d m0=%b required 1 1 %0d %b",
                 rx_dropped, line_valid, line_len, match0, e.len, e.m0);
      end
    end
    pulse_ack();
  endtask

  task automatic test_mid_reset();
    exp_t e;
    send_text("hel", 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_len = 0; m_disc = 1'b0;
    checks++;
    if ({line_valid, line_len, match0, match1, line_err, rx_dropped} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b len=%0d m0=%b m1=%b err=%b drop=%b required all 0",
               line_valid, line_len, match0, match1, line_err, rx_dropped);
    end
    send_byte(8'h61);
    send_byte(8'h0D);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL midrst_sb: DUT valid=%b, required a queued expected line", line_valid);
    end else begin
      e = sb.pop_front();
      if (line_valid !== 1'b1 || line_len !== LEN_W'(e.len) || match0 !== e.m0 || match1 !== e.m1) begin
        errors++;
        $display("FAIL midrst_line: valid=%b len=%0d m0=%b m1=%b required 1 %0d %b %b",
                 line_valid, line_len, match0, match1, e.len, e.m0, e.m1);
      end
    end
    pulse_ack();
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; line_ack = 1'b0;
    rx_byte = '0; rd_addr = '0;
    @(negedge clk);
    test_reset();
    test_cmd0();
    test_cmd1_crlf();
    test_backspace();
    test_overflow();
    test_error_and_drop();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected lines never presented, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
